load_store_unit: RTL and testbench

Memory-stage load/store sequencer for the MIPS datapath. Consumes the memory control signals produced by instruction decode (store byte-write mask, load width, zero-extend) together with the ALU-computed address. Drives a word-wide, byte-enabled data memory port through a request/acknowledge handshake. Returns aligned, sign- or zero-extended load data and a busy signal used to stall the pipeline.

---
 rtl/load_store_unit.sv | 190 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Memory-stage load/store sequencer: byte-lane store steering, load extraction/extension, req/ack memory port.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of aligning them down.
//
// state  | meaning
// IDLE   | waiting for start; latches the operation
// REQ    | mem_req held with stable outputs until mem_ack
// RESP   | done pulse (and misaligned pulse when trapped)
module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [3:0]  mem_write,
    input  logic        mem_read,
    input  logic [1:0]  read_width,
    input  logic        zero_ex,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
`ifdef MISALIGN_TRAP_EN
    output logic        misaligned,
`endif
    output logic [31:0] mem_addr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;
    typedef enum logic [1:0] {W_WORD, W_HALF, W_BYTE} width_t;

    state_t      state_q, state_d;
    width_t      width_q, width_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic        mem_we_q, mem_we_d;
    logic [1:0]  lane_q, lane_d;
    logic        zero_ex_q, zero_ex_d;
    logic        is_load_q, is_load_d;
    logic [31:0] load_data_q, load_data_d;

    logic   is_store, is_load, op_mis;
    width_t st_width, ld_width, op_width;

    assign is_store = (mem_write != 4'b0000);
    assign is_load  = mem_read;
    assign st_width = (mem_write == 4'b1111) ? W_WORD :
                      (mem_write == 4'b0011) ? W_HALF : W_BYTE;
    assign ld_width = (read_width == 2'd1) ? W_HALF :
                      (read_width == 2'd2) ? W_BYTE : W_WORD;
    assign op_width = is_store ? st_width : ld_width;

`ifdef MISALIGN_TRAP_EN
    logic mis_q, mis_d;
    assign op_mis = (op_width == W_HALF && addr[0]) ||
                    (op_width == W_WORD && addr[1:0] != 2'b00);
    assign misaligned = (state_q == S_RESP) && mis_q;
`else
    assign op_mis = 1'b0;
`endif

    function automatic logic [31:0] extract(input logic [31:0] word, input width_t w,
                                            input logic [1:0] lane, input logic zx);
        logic [15:0] h;
        logic [7:0]  b;
        h = lane[1] ? word[31:16] : word[15:0];
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        case (w)
            W_HALF:  extract = zx ? {16'h0, h} : {{16{h[15]}}, h};
            W_BYTE:  extract = zx ? {24'h0, b} : {{24{b[7]}}, b};
            default: extract = word;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        width_d     = width_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        mem_we_d    = mem_we_q;
        lane_d      = lane_q;
        zero_ex_d   = zero_ex_q;
        is_load_d   = is_load_q;
        load_data_d = load_data_q;
`ifdef MISALIGN_TRAP_EN
        mis_d       = mis_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mem_addr_d = {addr[31:2], 2'b00};
                    lane_d     = addr[1:0];
                    width_d    = op_width;
                    zero_ex_d  = zero_ex;
                    is_load_d  = !is_store && is_load;
`ifdef MISALIGN_TRAP_EN
                    mis_d      = (is_store || is_load) && op_mis;
`endif
                    if (is_store) begin
                        mem_we_d = 1'b1;
                        case (st_width)
                            W_WORD: begin
                                mem_be_d    = 4'b1111;
                                mem_wdata_d = store_data;
                            end
                            W_HALF: begin
                                mem_be_d    = addr[1] ? 4'b1100 : 4'b0011;
                                mem_wdata_d = {2{store_data[15:0]}};
                            end
                            default: begin
                                mem_be_d    = 4'b0001 << addr[1:0];
                                mem_wdata_d = {4{store_data[7:0]}};
                            end
                        endcase
                    end else if (is_load) begin
                        mem_we_d = 1'b0;
                        mem_be_d = 4'b1111;
                    end else begin
                        mem_we_d = 1'b0;
                        mem_be_d = 4'b0000;
                    end
                    // Trapped and no-op operations skip the memory request entirely
                    state_d = ((is_store || is_load) && !op_mis) ? S_REQ : S_RESP;
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    state_d = S_RESP;
                    if (is_load_q)
                        load_data_d = extract(mem_rdata, width_q, lane_q, zero_ex_q);
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            width_q     <= W_WORD;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_be_q    <= 4'h0;
            mem_we_q    <= 1'b0;
            lane_q      <= 2'b00;
            zero_ex_q   <= 1'b0;
            is_load_q   <= 1'b0;
            load_data_q <= 32'h0;
`ifdef MISALIGN_TRAP_EN
            mis_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            width_q     <= width_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            mem_we_q    <= mem_we_d;
            lane_q      <= lane_d;
            zero_ex_q   <= zero_ex_d;
            is_load_q   <= is_load_d;
            load_data_q <= load_data_d;
`ifdef MISALIGN_TRAP_EN
            mis_q       <= mis_d;
`endif
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_RESP);
    assign mem_req   = (state_q == S_REQ);
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign load_data = load_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stores, loads, stalls, no-op, reset abort, alignment handling.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic [3:0]  mem_write = 4'h0;
    logic        mem_read = 1'b0;
    logic [1:0]  read_width = 2'd0;
    logic        zero_ex = 1'b0;
    logic        busy, done;
    logic [31:0] load_data;
    logic [31:0] mem_addr;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
`ifdef MISALIGN_TRAP_EN
    logic        misaligned;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .reset(reset), .start(start), .addr(addr), .store_data(store_data),
        .mem_write(mem_write), .mem_read(mem_read), .read_width(read_width), .zero_ex(zero_ex),
        .busy(busy), .done(done), .load_data(load_data),
`ifdef MISALIGN_TRAP_EN
        .misaligned(misaligned),
`endif
        .mem_addr(mem_addr), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] sd, input logic [3:0] mw,
                         input logic rd, input logic [1:0] rw, input logic zx);
        start = 1'b1; addr = a; store_data = sd; mem_write = mw;
        mem_read = rd; read_width = rw; zero_ex = zx;
    endtask

    task automatic idle_inputs();
        start = 1'b0; mem_write = 4'h0; mem_read = 1'b0;
    endtask

    initial begin
        cyc();
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_req", {31'b0, mem_req}, 32'd0);
        chk("rst_we", {31'b0, mem_we}, 32'd0);
        chk("rst_be", {28'b0, mem_be}, 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_ldata", load_data, 32'h0);
        reset = 1'b0;

        // SB at 0x102, ack in cycle 1
        cyc();
        issue(32'h102, 32'h0000_00A5, 4'b0001, 1'b0, 2'd0, 1'b0);
        chk("sb_c0_busy", {31'b0, busy}, 32'd0);
        cyc();
        idle_inputs();
        chk("sb_req", {31'b0, mem_req}, 32'd1);
        chk("sb_addr", mem_addr, 32'h100);
        chk("sb_be", {28'b0, mem_be}, 32'b0100);
        chk("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
        chk("sb_we", {31'b0, mem_we}, 32'd1);
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
        chk("sb_done", {31'b0, done}, 32'd1);
        chk("sb_req_drop", {31'b0, mem_req}, 32'd0);
        cyc();
        chk("sb_done_pulse", {31'b0, done}, 32'd0);
        chk("sb_idle", {31'b0, busy}, 32'd0);

        // LB at 0x3, sign-extended
        issue(32'h3, 32'h0, 4'b0000, 1'b1, 2'd2, 1'b0);
        cyc();
        idle_inputs();
        chk("lb_req", {31'b0, mem_req}, 32'd1);
        chk("lb_we", {31'b0, mem_we}, 32'd0);
        chk("lb_be", {28'b0, mem_be}, 32'b1111);
        chk("lb_addr", mem_addr, 32'h0);
        mem_ack = 1'b1; mem_rdata = 32'h80FF_7F01;
        cyc();
        mem_ack = 1'b0;
        chk("lb_done", {31'b0, done}, 32'd1);
        chk("lb_data", load_data, 32'hFFFF_FF80);
        cyc();

        // LBU: same access, zero-extended
        issue(32'h3, 32'h0, 4'b0000, 1'b1, 2'd2, 1'b1);
        cyc();
        idle_inputs();
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
        chk("lbu_data", load_data, 32'h0000_0080);
        cyc();

        // LH at 0x2 with ack delayed to the third REQ cycle
        issue(32'h2, 32'h0, 4'b0000, 1'b1, 2'd1, 1'b0);
        mem_rdata = 32'h8001_1234;
        cyc();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            chk("lh_req_held", {31'b0, mem_req}, 32'd1);
            chk("lh_addr_stable", mem_addr, 32'h0);
            chk("lh_be_stable", {28'b0, mem_be}, 32'b1111);
            chk("lh_busy", {31'b0, busy}, 32'd1);
            chk("lh_no_done", {31'b0, done}, 32'd0);
            if (i == 2) mem_ack = 1'b1;
            cyc();
        end
        mem_ack = 1'b0;
        chk("lh_done", {31'b0, done}, 32'd1);
        chk("lh_busy_c4", {31'b0, busy}, 32'd1);
        chk("lh_data", load_data, 32'hFFFF_8001);
        cyc();
        chk("lh_busy_end", {31'b0, busy}, 32'd0);

        // SH at 0x0E: upper half lanes; load_data must hold
        issue(32'hE, 32'h1234_ABCD, 4'b0011, 1'b0, 2'd0, 1'b0);
        cyc();
        idle_inputs();
        chk("sh_addr", mem_addr, 32'hC);
        chk("sh_be", {28'b0, mem_be}, 32'b1100);
        chk("sh_wdata", mem_wdata, 32'hABCD_ABCD);
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
        chk("sh_ldata_hold", load_data, 32'hFFFF_8001);
        cyc();

        // Store mask plus mem_read: store wins
        issue(32'h20, 32'hCAFE_F00D, 4'b1111, 1'b1, 2'd2, 1'b0);
        cyc();
        idle_inputs();
        chk("prio_we", {31'b0, mem_we}, 32'd1);
        chk("prio_wdata", mem_wdata, 32'hCAFE_F00D);
        mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
        cyc();
        mem_ack = 1'b0;
        chk("prio_ldata_hold", load_data, 32'hFFFF_8001);
        cyc();

        // No-op, with a second start while busy and a stray ack
        issue(32'h0, 32'h0, 4'b0000, 1'b0, 2'd0, 1'b0);
        cyc();
        chk("noop_done", {31'b0, done}, 32'd1);
        chk("noop_no_req", {31'b0, mem_req}, 32'd0);
        chk("noop_busy", {31'b0, busy}, 32'd1);
        issue(32'h80, 32'h5, 4'b1111, 1'b0, 2'd0, 1'b0);
        mem_ack = 1'b1;
        cyc();
        idle_inputs();
        chk("busy_start_ignored", {31'b0, busy}, 32'd0);
        chk("busy_start_no_req", {31'b0, mem_req}, 32'd0);
        cyc();
        mem_ack = 1'b0;
        chk("stray_ack_ignored", {31'b0, busy}, 32'd0);

        // Reset in the middle of REQ
        issue(32'h1, 32'h0, 4'b0000, 1'b1, 2'd2, 1'b1);
        cyc();
        idle_inputs();
        chk("abort_req_before", {31'b0, mem_req}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("abort_req", {31'b0, mem_req}, 32'd0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_ldata", load_data, 32'h0);
        cyc();
        reset = 1'b0;

        // SW to 0x40 after reset
        issue(32'h40, 32'hDEAD_BEEF, 4'b1111, 1'b0, 2'd0, 1'b0);
        cyc();
        idle_inputs();
        chk("sw_req", {31'b0, mem_req}, 32'd1);
        chk("sw_addr", mem_addr, 32'h40);
        chk("sw_be", {28'b0, mem_be}, 32'b1111);
        chk("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
        mem_ack = 1'b1;
        cyc();
        mem_ack = 1'b0;
        chk("sw_done", {31'b0, done}, 32'd1);
        cyc();

        // Give load_data a known nonzero value, then LW at 0x41
        issue(32'h4, 32'h0, 4'b0000, 1'b1, 2'd1, 1'b1);
        cyc();
        idle_inputs();
        mem_ack = 1'b1; mem_rdata = 32'h0000_9876;
        cyc();
        mem_ack = 1'b0;
        chk("lhu_data", load_data, 32'h0000_9876);
        cyc();
        issue(32'h41, 32'h0, 4'b0000, 1'b1, 2'd0, 1'b0);
        cyc();
        idle_inputs();
`ifdef MISALIGN_TRAP_EN
        chk("mis_no_req", {31'b0, mem_req}, 32'd0);
        chk("mis_done", {31'b0, done}, 32'd1);
        chk("mis_flag", {31'b0, misaligned}, 32'd1);
        chk("mis_ldata", load_data, 32'h0000_9876);
        cyc();
        chk("mis_pulse", {31'b0, misaligned}, 32'd0);
`else
        chk("lw_align_req", {31'b0, mem_req}, 32'd1);
        chk("lw_align_addr", mem_addr, 32'h40);
        mem_ack = 1'b1; mem_rdata = 32'h1122_3344;
        cyc();
        mem_ack = 1'b0;
        chk("lw_align_data", load_data, 32'h1122_3344);
`endif
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
